// File: rtl/reg_if.sv
// reg_if: host-mapped control, status, scratch and ID register block
module reg_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE = 32'h5245_4701
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] status
);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(8'h0C);
  localparam logic [DATA_WIDTH-1:0] ID        = DATA_WIDTH'(ID_VALUE);
  logic [DATA_WIDTH-1:0] ctrl_reg, scratch_reg, status_reg, rd_val;
  always_comb
    rd_val = addr == A_CTRL    ? ctrl_reg    :
             addr == A_STATUS  ? status_reg  :
             addr == A_SCRATCH ? scratch_reg :
             addr == A_ID      ? ID          : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl_reg    <= '0;
      scratch_reg <= '0;
      status_reg  <= '0;
      rdata       <= '0;
    end else begin
      status_reg <= status_in;
      if (wen && addr == A_CTRL) ctrl_reg <= wdata;
      if (wen && addr == A_SCRATCH) scratch_reg <= wdata;
      if (ren) rdata <= rd_val;
    end
  assign ctrl   = ctrl_reg;
  assign status = status_reg;
endmodule

// File: tb/tb_reg_if.sv
// tb_reg_if: directed self-checking bench for reg_if
module tb_reg_if;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [7:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic        wen = 0;
  logic        ren = 0;
  logic [31:0] ctrl;
  logic [31:0] status_in = 0;
  logic [31:0] status;
  int errs = 0;
  int checks = 0;

  reg_if dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .rdata(rdata),
    .wen(wen), .ren(ren), .ctrl(ctrl), .status_in(status_in), .status(status)
  );

  always #5 clk = ~clk;

  task automatic bus(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = wr; ren = rd; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wen = 0; ren = 0;
  endtask

  task automatic test_reset;
    status_in = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ctrl !== 32'h0) begin errs++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl, 32'h0); end
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (status !== 32'h0) begin errs++; $display("FAIL reset_status got=%h exp=%h", status, 32'h0); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_ctrl;
    bus(1, 0, 8'h00, 32'h0000_00FF);
    checks++; if (ctrl !== 32'h0000_00FF) begin errs++; $display("FAIL ctrl_write got=%h exp=%h", ctrl, 32'hFF); end
    bus(0, 1, 8'h00, 32'h0);
    checks++; if (rdata !== 32'h0000_00FF) begin errs++; $display("FAIL ctrl_read got=%h exp=%h", rdata, 32'hFF); end
  endtask

  task automatic test_status;
    @(negedge clk);
    status_in = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    status_in = 32'h0F0F_0F0F;
    checks++; if (status !== 32'hA5A5_A5A5) begin errs++; $display("FAIL status_latency got=%h exp=%h", status, 32'hA5A5_A5A5); end
    bus(0, 1, 8'h04, 32'h0);
    checks++; if (rdata !== 32'hA5A5_A5A5) begin errs++; $display("FAIL status_read got=%h exp=%h", rdata, 32'hA5A5_A5A5); end
  endtask

  task automatic test_async_reset;
    bus(1, 0, 8'h08, 32'h5555_AAAA);
    bus(0, 1, 8'h00, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    checks++; if (ctrl !== 32'h0) begin errs++; $display("FAIL areset_ctrl got=%h exp=%h", ctrl, 32'h0); end
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL areset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (status !== 32'h0) begin errs++; $display("FAIL areset_status got=%h exp=%h", status, 32'h0); end
    status_in = 32'h3C3C_3C3C;
    @(negedge clk);
    reset_n = 1;
    bus(0, 1, 8'h00, 32'h0);
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL areset_ctrl_read got=%h exp=%h", rdata, 32'h0); end
    bus(0, 1, 8'h08, 32'h0);
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL areset_scratch_read got=%h exp=%h", rdata, 32'h0); end
    bus(0, 1, 8'h04, 32'h0);
    checks++; if (rdata !== 32'h3C3C_3C3C) begin errs++; $display("FAIL areset_status_read got=%h exp=%h", rdata, 32'h3C3C_3C3C); end
  endtask

  task automatic test_scratch_ro;
    bus(1, 0, 8'h08, 32'hDEAD_BEEF);
    bus(0, 1, 8'h08, 32'h0);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL scratch_read got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    bus(1, 0, 8'h04, 32'h1234_5678);
    bus(1, 0, 8'h0C, 32'h1234_5678);
    checks++; if (status !== 32'h3C3C_3C3C) begin errs++; $display("FAIL status_ro got=%h exp=%h", status, 32'h3C3C_3C3C); end
    checks++; if (ctrl !== 32'h0) begin errs++; $display("FAIL ro_write_ctrl got=%h exp=%h", ctrl, 32'h0); end
    bus(0, 1, 8'h04, 32'h0);
    checks++; if (rdata !== 32'h3C3C_3C3C) begin errs++; $display("FAIL status_ro_read got=%h exp=%h", rdata, 32'h3C3C_3C3C); end
    bus(0, 1, 8'h0C, 32'h0);
    checks++; if (rdata !== 32'h5245_4701) begin errs++; $display("FAIL id_read got=%h exp=%h", rdata, 32'h5245_4701); end
    bus(0, 1, 8'h08, 32'h0);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL scratch_keep got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_unmapped_hold;
    bus(0, 1, 8'h0C, 32'h0);
    bus(0, 1, 8'h10, 32'h0);
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL unmapped_10 got=%h exp=%h", rdata, 32'h0); end
    bus(0, 1, 8'h0C, 32'h0);
    bus(0, 1, 8'h02, 32'h0);
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL unmapped_02 got=%h exp=%h", rdata, 32'h0); end
    bus(1, 0, 8'h10, 32'hFFFF_FFFF);
    bus(0, 1, 8'h0C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus(0, 0, 8'(i * 4), 32'hFFFF_FFFF);
      checks++; if (rdata !== 32'h5245_4701) begin errs++; $display("FAIL hold_%0d got=%h exp=%h", i, rdata, 32'h5245_4701); end
    end
    checks++; if (ctrl !== 32'h0) begin errs++; $display("FAIL idle_ctrl got=%h exp=%h", ctrl, 32'h0); end
  endtask

  task automatic test_back_to_back;
    bus(1, 0, 8'h00, 32'h1);
    bus(1, 1, 8'h00, 32'h2);
    checks++; if (rdata !== 32'h1) begin errs++; $display("FAIL rw_same_old got=%h exp=%h", rdata, 32'h1); end
    checks++; if (ctrl !== 32'h2) begin errs++; $display("FAIL rw_same_ctrl got=%h exp=%h", ctrl, 32'h2); end
    bus(0, 1, 8'h00, 32'h0);
    checks++; if (rdata !== 32'h2) begin errs++; $display("FAIL rw_same_next got=%h exp=%h", rdata, 32'h2); end
    bus(1, 1, 8'h08, 32'hCAFE_0001);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rw_scratch_old got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    bus(0, 1, 8'h08, 32'h0);
    checks++; if (rdata !== 32'hCAFE_0001) begin errs++; $display("FAIL rw_scratch_new got=%h exp=%h", rdata, 32'hCAFE_0001); end
  endtask

  initial begin
    test_reset;
    test_ctrl;
    test_status;
    test_async_reset;
    test_scratch_ro;
    test_unmapped_hold;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
